// File: rtl/char_mover.sv
// rtl/char_mover.sv - tile-aligned sprite movement controller with wall probing
// Purpose: moves a 16x16 sprite one pixel per frame tick over a tile map,
//   turning on player requests and stopping at walls probed via a map port.
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_frame_tick            one-cycle movement strobe per frame
//   i_req_valid, i_req_dir  player request (0 up, 1 down, 2 left, 3 right)
//   o_query_tx/ty/valid     map tile probe; i_query_wall answers one cycle later
//   i_query_wall            wall flag for the previously presented tile
//   o_char_x, o_char_y      sprite top-left position in pixels
//   o_dir, o_moving         current direction, last tick produced a step
//   o_anim_frame            walk animation index
//   o_tick_miss             one-cycle pulse when a tick arrives while busy
module char_mover #(
  parameter int X_SIZE  = 288,
  parameter int Y_SIZE  = 224,
  parameter int START_X = 136,
  parameter int START_Y = 104
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_tick,
  input  logic       i_req_valid,
  input  logic [1:0] i_req_dir,
  output logic [5:0] o_query_tx,
  output logic [4:0] o_query_ty,
  output logic       o_query_valid,
  input  logic       i_query_wall,
  output logic [9:0] o_char_x,
  output logic [9:0] o_char_y,
  output logic [1:0] o_dir,
  output logic       o_moving,
  output logic [1:0] o_anim_frame,
  output logic       o_tick_miss
);

  localparam int X_TILES = X_SIZE / 8;
  localparam int Y_TILES = Y_SIZE / 8;
  localparam logic [9:0] X_LAST = 10'(X_SIZE - 1);

  typedef enum logic [2:0] {IDLE, REQ_Q, REQ_W, CUR_Q, CUR_W, STEP} state_t;

  // forced: probe falls off the top/bottom edge, treated as a wall with no query
  typedef struct packed {
    logic       forced;
    logic [5:0] tx;
    logic [4:0] ty;
  } probe_t;

  state_t     state;
  logic [1:0] req_dir_q;
  logic       forced_wall;
  logic [1:0] pix_cnt;

  logic       aligned;
  logic [5:0] base_tx;
  logic [4:0] base_ty;
  probe_t     probe_req;
  probe_t     probe_cur;

  function automatic probe_t probe(input logic [1:0] d, input logic [5:0] tx,
                                   input logic [4:0] ty);
    probe_t p;
    p.forced = 1'b0;
    p.tx     = tx;
    p.ty     = ty;
    case (d)
      2'd0: if (ty == 5'd0) p.forced = 1'b1;
            else p.ty = ty - 5'd1;
      2'd1: if (({1'b0, ty} + 6'd2) >= 6'(Y_TILES)) p.forced = 1'b1;
            else p.ty = ty + 5'd2;
      2'd2: p.tx = (tx == 6'd0) ? 6'(X_TILES - 1) : tx - 6'd1;
      default: p.tx = (tx >= 6'(X_TILES - 2)) ? tx - 6'(X_TILES - 2) : tx + 6'd2;
    endcase
    return p;
  endfunction

  assign aligned   = (o_char_x[2:0] == 3'd0) && (o_char_y[2:0] == 3'd0);
  assign base_tx   = o_char_x[8:3];
  assign base_ty   = o_char_y[7:3];
  assign probe_req = probe(i_req_dir, base_tx, base_ty);
  assign probe_cur = probe(o_dir, base_tx, base_ty);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      o_char_x      <= 10'(START_X);
      o_char_y      <= 10'(START_Y);
      o_dir         <= 2'd2;
      o_moving      <= 1'b0;
      o_anim_frame  <= 2'd0;
      pix_cnt       <= 2'd0;
      o_query_valid <= 1'b0;
      o_query_tx    <= 6'd0;
      o_query_ty    <= 5'd0;
      o_tick_miss   <= 1'b0;
      req_dir_q     <= 2'd0;
      forced_wall   <= 1'b0;
    end else begin
      o_query_valid <= 1'b0;
      // ticks are never queued: any tick outside IDLE is dropped and flagged
      o_tick_miss   <= i_frame_tick && (state != IDLE);
      case (state)
        IDLE: begin
          if (i_frame_tick) begin
            if (i_req_valid && (i_req_dir == (o_dir ^ 2'd1))) begin
              // reversing never needs a probe: the tiles behind are known clear
              o_dir <= i_req_dir;
              state <= STEP;
            end else if (i_req_valid && aligned && (i_req_dir != o_dir)) begin
              req_dir_q     <= i_req_dir;
              forced_wall   <= probe_req.forced;
              o_query_valid <= !probe_req.forced;
              if (!probe_req.forced) begin
                o_query_tx <= probe_req.tx;
                o_query_ty <= probe_req.ty;
              end
              state <= REQ_Q;
            end else begin
              forced_wall   <= probe_cur.forced;
              o_query_valid <= !probe_cur.forced;
              if (!probe_cur.forced) begin
                o_query_tx <= probe_cur.tx;
                o_query_ty <= probe_cur.ty;
              end
              state <= CUR_Q;
            end
          end
        end
        REQ_Q: state <= REQ_W;
        REQ_W: begin
          if (i_query_wall || forced_wall) begin
            // requested turn blocked: fall back to probing the current direction
            forced_wall   <= probe_cur.forced;
            o_query_valid <= !probe_cur.forced;
            if (!probe_cur.forced) begin
              o_query_tx <= probe_cur.tx;
              o_query_ty <= probe_cur.ty;
            end
            state <= CUR_Q;
          end else begin
            o_dir <= req_dir_q;
            state <= STEP;
          end
        end
        CUR_Q: state <= CUR_W;
        CUR_W: begin
          // between tiles the path is already committed, so the probe is ignored
          if (aligned && (i_query_wall || forced_wall)) begin
            o_moving <= 1'b0;
            state    <= IDLE;
          end else begin
            state <= STEP;
          end
        end
        STEP: begin
          case (o_dir)
            2'd0: o_char_y <= o_char_y - 10'd1;
            2'd1: o_char_y <= o_char_y + 10'd1;
            2'd2: o_char_x <= (o_char_x == 10'd0) ? X_LAST : o_char_x - 10'd1;
            default: o_char_x <= (o_char_x == X_LAST) ? 10'd0 : o_char_x + 10'd1;
          endcase
          o_moving <= 1'b1;
          pix_cnt  <= pix_cnt + 2'd1;
          if (pix_cnt == 2'd3) o_anim_frame <= o_anim_frame + 2'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_char_mover.sv
// tb/tb_char_mover.sv - randomized and directed bench for char_mover against a per-tick model
module tb_char_mover;

  localparam int XS = 288;
  localparam int XT = 36;
  localparam int YT = 28;

  logic       clk = 1'b0;
  logic       rst_n, tick, rv, wall;
  logic [1:0] rd;
  logic [5:0] q_tx;
  logic [4:0] q_ty;
  logic       q_valid, moving, tick_miss;
  logic [9:0] cx, cy;
  logic [1:0] dir, anim;

  always #5 clk = ~clk;

  char_mover dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(tick), .i_req_valid(rv), .i_req_dir(rd),
    .o_query_tx(q_tx), .o_query_ty(q_ty), .o_query_valid(q_valid), .i_query_wall(wall),
    .o_char_x(cx), .o_char_y(cy), .o_dir(dir), .o_moving(moving),
    .o_anim_frame(anim), .o_tick_miss(tick_miss)
  );

  bit wall_map [XT][YT];
  int checks = 0;
  int failures = 0;
  bit en = 0;

  // model: position/direction after each accepted tick, plus how long the tick keeps the block busy
  int m_x, m_y, m_dir, m_moving, m_steps, m_busy;
  bit m_miss;
  int p_x, p_y, p_dir, p_moving, p_steps;
  int exp_q[$];
  int obs_q[$];

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, want, $time);
    end
  endtask

  function automatic void probe(input int d, input int x, input int y,
                                output bit blk, output bit queried, output int addr);
    int tx = x / 8;
    int ty = y / 8;
    int ptx = tx;
    int pty = ty;
    queried = 1;
    case (d)
      0: if (ty == 0) queried = 0; else pty = ty - 1;
      1: if (ty + 2 >= YT) queried = 0; else pty = ty + 2;
      2: ptx = (tx + XT - 1) % XT;
      default: ptx = (tx + 2) % XT;
    endcase
    addr = ptx * 32 + pty;
    blk  = queried ? wall_map[ptx][pty] : 1'b1;
  endfunction

  function automatic void plan_step(input int d);
    case (d)
      0: p_y = p_y - 1;
      1: p_y = p_y + 1;
      2: p_x = (p_x == 0) ? XS - 1 : p_x - 1;
      default: p_x = (p_x == XS - 1) ? 0 : p_x + 1;
    endcase
    p_moving = 1;
    p_steps  = p_steps + 1;
  endfunction

  task automatic eval_tick();
    bit blk, qd, done, al;
    int a, slots;
    done = 0;
    slots = 0;
    al = (m_x % 8 == 0) && (m_y % 8 == 0);
    p_x = m_x; p_y = m_y; p_dir = m_dir; p_moving = m_moving; p_steps = m_steps;
    if (rv && int'(rd) == (m_dir ^ 1)) begin
      p_dir = int'(rd);
      plan_step(p_dir);
      m_busy = 1;
    end else begin
      if (rv && al && int'(rd) != m_dir) begin
        slots = 2;
        probe(int'(rd), m_x, m_y, blk, qd, a);
        if (qd) exp_q.push_back(a);
        if (!blk) begin
          p_dir = int'(rd);
          plan_step(p_dir);
          m_busy = 3;
          done = 1;
        end
      end
      if (!done) begin
        slots += 2;
        probe(m_dir, m_x, m_y, blk, qd, a);
        if (qd) exp_q.push_back(a);
        if (al && blk) begin
          p_moving = 0;
          m_busy = slots;
        end else begin
          plan_step(m_dir);
          m_busy = slots + 1;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_x = 136; m_y = 104; m_dir = 2; m_moving = 0; m_steps = 0;
      m_busy = 0; m_miss = 0;
      exp_q.delete();
    end else if (m_busy > 0) begin
      m_miss = tick;
      m_busy--;
      if (m_busy == 0) begin
        m_x = p_x; m_y = p_y; m_dir = p_dir; m_moving = p_moving; m_steps = p_steps;
      end
    end else begin
      m_miss = 0;
      if (tick) eval_tick();
    end
  end

  // compare process
  always @(negedge clk) begin
    if (en) begin
      chk("tick_miss", int'(tick_miss), int'(m_miss));
      if (q_valid) begin
        obs_q.push_back(int'(q_tx) * 32 + int'(q_ty));
        if (exp_q.size() == 0) chk("query_unexpected", int'(q_tx) * 32 + int'(q_ty), -1);
        else chk("query_addr", int'(q_tx) * 32 + int'(q_ty), exp_q.pop_front());
      end
      if (m_busy == 0) begin
        chk("x", int'(cx), m_x);
        chk("y", int'(cy), m_y);
        chk("dir", int'(dir), m_dir);
        chk("moving", int'(moving), m_moving);
        chk("anim", int'(anim), (m_steps / 4) % 4);
        chk("query_missing", exp_q.size(), 0);
      end
    end
  end

  // map memory with one cycle of latency; garbage when no query is outstanding
  bit pend = 0;
  int ptx, pty;
  initial begin
    wall = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) wall = (ptx < XT && pty < YT) ? wall_map[ptx][pty] : 1'b1;
      else wall = 1'($urandom % 2);
      pend = q_valid;
      ptx = int'(q_tx);
      pty = int'(q_ty);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (m_busy != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (m_busy != 0) chk("idle_timeout", m_busy, 0);
  endtask

  task automatic do_tick(input bit v, input logic [1:0] d);
    @(negedge clk);
    tick = 1'b1; rv = v; rd = d;
    @(negedge clk);
    tick = 1'b0; rv = 1'b0;
    wait_idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; tick = 1'b0; rv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_map();
    for (int i = 0; i < XT; i++)
      for (int j = 0; j < YT; j++) wall_map[i][j] = 1'b0;
  endtask

  function automatic int obs_at(input int i);
    return (obs_q.size() > i) ? obs_q[i] : -1;
  endfunction

  initial begin
    int anim_exp[4];
    anim_exp = '{1, 2, 3, 0};
    rst_n = 1'b0; tick = 1'b0; rv = 1'b0; rd = 2'd0;
    clear_map();
    @(negedge clk);
    en = 1;
    chk("rst_x", int'(cx), 136);
    chk("rst_y", int'(cy), 104);
    chk("rst_dir", int'(dir), 2);
    chk("rst_moving", int'(moving), 0);
    chk("rst_anim", int'(anim), 0);
    chk("rst_qvalid", int'(q_valid), 0);
    chk("rst_miss", int'(tick_miss), 0);
    rst_n = 1'b1;

    // turn up blocked, fall back to left
    wall_map[17][12] = 1'b1;
    obs_q.delete();
    do_tick(1'b1, 2'd0);
    chk("turn_blk_dir", int'(dir), 2);
    chk("turn_blk_x", int'(cx), 135);
    chk("turn_blk_nq", obs_q.size(), 2);
    chk("turn_blk_q0", obs_at(0), 17 * 32 + 12);
    chk("turn_blk_q1", obs_at(1), 16 * 32 + 13);
    wall_map[17][12] = 1'b0;

    // plain tick from reset
    do_reset();
    obs_q.delete();
    do_tick(1'b0, 2'd0);
    chk("first_x", int'(cx), 135);
    chk("first_moving", int'(moving), 1);
    chk("first_nq", obs_q.size(), 1);
    chk("first_q", obs_at(0), 16 * 32 + 13);

    // reverse while unaligned: no probe
    obs_q.delete();
    do_tick(1'b1, 2'd3);
    chk("rev_nq", obs_q.size(), 0);
    chk("rev_dir", int'(dir), 3);
    chk("rev_x", int'(cx), 136);

    // wall ahead, plus a tick dropped while busy
    wall_map[19][13] = 1'b1;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("miss_pulse", int'(tick_miss), 1);
    tick = 1'b0;
    wait_idle();
    chk("blk_moving", int'(moving), 0);
    chk("blk_x", int'(cx), 136);
    chk("blk_y", int'(cy), 104);
    wall_map[19][13] = 1'b0;

    // animation cadence
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      do_tick(1'b0, 2'd0);
      if (k % 4 == 0) chk("anim_seq", int'(anim), anim_exp[k / 4 - 1]);
    end

    // reset landing in the current-direction wait state
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("abort_x", int'(cx), 136);
    chk("abort_dir", int'(dir), 2);
    chk("abort_moving", int'(moving), 0);
    chk("abort_qvalid", int'(q_valid), 0);
    repeat (6) @(negedge clk);
    chk("abort_nostep", int'(cx), 136);

    // horizontal wrap both ways
    for (int k = 0; k < 136; k++) do_tick(1'b0, 2'd0);
    chk("wrap_at0", int'(cx), 0);
    do_tick(1'b0, 2'd0);
    chk("wrap_left", int'(cx), 287);
    do_tick(1'b1, 2'd3);
    chk("wrap_right", int'(cx), 0);
    chk("wrap_dir", int'(dir), 3);
    chk("wrap_y", int'(cy), 104);

    // randomized run on a random map
    do_reset();
    for (int i = 0; i < XT; i++)
      for (int j = 0; j < YT; j++) wall_map[i][j] = ($urandom_range(0, 99) < 25);
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      tick  = ($urandom_range(0, 3) == 0);
      rv    = 1'($urandom % 2);
      rd    = 2'($urandom % 4);
      rst_n = ($urandom_range(0, 999) != 0);
    end
    @(negedge clk);
    tick = 1'b0; rv = 1'b0; rst_n = 1'b1;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
